// File: rtl/motor_ramp_scheduler_pkg.sv
// motor_ramp_scheduler_pkg: shared duty width, default channel count and sweep FSM encoding.
//   PERIOD_LENGTH : width of period / duty / step values
//   NUM_MOTORS    : default number of scheduled H-bridge channels
//   state_t       : IDLE (accepting commands), UPDATE (one channel per cycle), DONE (one-cycle gap)
package motor_ramp_scheduler_pkg;
    localparam int PERIOD_LENGTH = 16;
    localparam int NUM_MOTORS    = 4;
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_DONE   = 2'd2
    } state_t;
endpackage

// File: rtl/motor_ramp_step.sv
// motor_ramp_step: one ramp step for a single channel, moving duty toward its target without crossing center.
//   i_on     : channel enable; when low the result snaps to center
//   i_cur    : current duty
//   i_tgt    : target duty, already clamped to the live period
//   i_center : period >> 1 (brake point)
//   i_step   : maximum movement for this step
//   o_next   : duty after this step
module motor_ramp_step
    import motor_ramp_scheduler_pkg::*;
#(
    parameter int W = PERIOD_LENGTH
) (
    input  logic         i_on,
    input  logic [W-1:0] i_cur,
    input  logic [W-1:0] i_tgt,
    input  logic [W-1:0] i_center,
    input  logic [W-1:0] i_step,
    output logic [W-1:0] o_next
);
    logic         w_opposite;
    logic [W-1:0] w_goal;
    logic [W-1:0] w_dist;

    // A reversal is split across ticks: first head for center, only later for the far-side target.
    // All moves are bounded by w_dist, so nothing ever wraps past 0 or the goal.
    always_comb begin
        w_opposite = (i_cur > i_center && i_tgt < i_center) || (i_cur < i_center && i_tgt > i_center);
        w_goal     = w_opposite ? i_center : i_tgt;
        w_dist     = (w_goal >= i_cur) ? w_goal - i_cur : i_cur - w_goal;
        if (!i_on)
            o_next = i_center;
        else if (i_step >= w_dist)
            o_next = w_goal;
        else if (w_goal > i_cur)
            o_next = i_cur + i_step;
        else
            o_next = i_cur - i_step;
    end
endmodule

// File: rtl/motor_ramp_scheduler.sv
// motor_ramp_scheduler: per-tick duty ramping for several H-bridge channels with a command watchdog.
//   clk, reset_n : single clock, synchronous active-low reset
//   period, step : shared PWM period (center = period>>1) and max duty change per tick
//   cmd_*        : valid/ready command writing enable and target of one channel
//   on_out       : per-channel enable
//   duty_out     : per-channel current duty, channel i at [i*PERIOD_LENGTH +: PERIOD_LENGTH]
//   wdt_tripped  : watchdog forced every channel off; cleared by the next accepted command
module motor_ramp_scheduler #(
    parameter int NUM_MOTORS    = motor_ramp_scheduler_pkg::NUM_MOTORS,
    parameter int PERIOD_LENGTH = motor_ramp_scheduler_pkg::PERIOD_LENGTH,
    parameter int TICK_DIV      = 16000,
    parameter int WDT_TICKS     = 500
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic [PERIOD_LENGTH-1:0]                        period,
    input  logic [PERIOD_LENGTH-1:0]                        step,
    input  logic                                            cmd_valid,
    output logic                                            cmd_ready,
    input  logic [$clog2(NUM_MOTORS > 1 ? NUM_MOTORS : 2)-1:0] cmd_motor,
    input  logic                                            cmd_on,
    input  logic [PERIOD_LENGTH-1:0]                        cmd_duty,
    output logic [NUM_MOTORS-1:0]                           on_out,
    output logic [NUM_MOTORS*PERIOD_LENGTH-1:0]             duty_out,
    output logic                                            wdt_tripped
);
    import motor_ramp_scheduler_pkg::*;

    localparam int W     = PERIOD_LENGTH;
    localparam int IDX_W = $clog2(NUM_MOTORS > 1 ? NUM_MOTORS : 2);
    localparam int PW    = $clog2(TICK_DIV);
    localparam int WW    = $clog2(WDT_TICKS + 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [PW-1:0]    r_presc;
    logic [WW-1:0]    r_wdt;
    logic             r_tripped;
    logic [IDX_W-1:0] r_idx;
    logic [NUM_MOTORS-1:0] r_on;
    logic [W-1:0]     r_target [NUM_MOTORS];
    logic [W-1:0]     r_duty   [NUM_MOTORS];
    logic             w_tick;
    logic             w_accept;
    logic             w_last;
    logic             w_trip;
    logic [W-1:0]     w_center;
    logic [W-1:0]     w_cmd_tgt;
    logic [W-1:0]     w_tgt;
    logic [W-1:0]     w_next;

    assign w_center  = period >> 1;
    assign w_tick    = r_presc == PW'(TICK_DIV - 1);
    assign cmd_ready = r_state == S_IDLE;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_last    = r_idx == IDX_W'(NUM_MOTORS - 1);
    assign w_cmd_tgt = (cmd_duty > period) ? period : cmd_duty;
    // Stored targets are re-clamped so a shrinking period takes effect at the next sweep.
    assign w_tgt     = (r_target[r_idx] > period) ? period : r_target[r_idx];
    // An accepted command outranks a trip landing in the same cycle.
    assign w_trip    = w_tick && !w_accept && !r_tripped && r_wdt == WW'(WDT_TICKS - 1);

    motor_ramp_step #(.W(W)) u_step (
        .i_on     (r_on[r_idx]),
        .i_cur    (r_duty[r_idx]),
        .i_tgt    (w_tgt),
        .i_center (w_center),
        .i_step   (step),
        .o_next   (w_next)
    );

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = S_IDLE;
        case (r_state)
            S_IDLE:   w_state_next = w_tick ? S_UPDATE : S_IDLE;
            S_UPDATE: w_state_next = w_last ? S_DONE : S_UPDATE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_presc   <= '0;
            r_wdt     <= '0;
            r_tripped <= 1'b0;
            r_on      <= '0;
            r_idx     <= '0;
            for (int i = 0; i < NUM_MOTORS; i++) begin
                r_target[i] <= w_center;
                r_duty[i]   <= w_center;
            end
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            r_idx   <= (r_state == S_UPDATE && !w_last) ? r_idx + 1'b1 : '0;
            if (r_state == S_UPDATE)
                r_duty[r_idx] <= w_next;
            if (w_accept) begin
                r_wdt               <= '0;
                r_tripped           <= 1'b0;
                r_on[cmd_motor]     <= cmd_on;
                r_target[cmd_motor] <= w_cmd_tgt;
            end else if (w_trip) begin
                r_wdt     <= '0;
                r_tripped <= 1'b1;
                r_on      <= '0;
                for (int i = 0; i < NUM_MOTORS; i++) begin
                    r_target[i] <= w_center;
                    r_duty[i]   <= w_center;
                end
            end else if (w_tick && !r_tripped) begin
                r_wdt <= r_wdt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_duty
        assign duty_out[i*W +: W] = r_duty[i];
    end

    assign on_out      = r_on;
    assign wdt_tripped = r_tripped;
endmodule

// File: tb/tb_motor_ramp_scheduler.sv
// tb_motor_ramp_scheduler: directed ramp/watchdog scenarios plus randomized traffic against a tick-level model.
module tb_motor_ramp_scheduler;
    localparam int N   = 4;
    localparam int W   = 16;
    localparam int TD  = 8;
    localparam int WDT = 3;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [W-1:0]   period = 16'd1000;
    logic [W-1:0]   step = 16'd100;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [1:0]     cmd_motor = 2'd0;
    logic           cmd_on = 1'b0;
    logic [W-1:0]   cmd_duty = '0;
    logic [N-1:0]   on_out;
    logic [N*W-1:0] duty_out;
    logic           wdt_tripped;

    int n_cmp = 0;
    int n_bad = 0;

    motor_ramp_scheduler #(.NUM_MOTORS(N), .PERIOD_LENGTH(W), .TICK_DIV(TD), .WDT_TICKS(WDT)) dut (
        .clk(clk), .reset_n(reset_n), .period(period), .step(step),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_motor(cmd_motor),
        .cmd_on(cmd_on), .cmd_duty(cmd_duty), .on_out(on_out),
        .duty_out(duty_out), .wdt_tripped(wdt_tripped)
    );

    always #5 clk = ~clk;

    // Model state: time is counted in cycles since reset; a sweep occupies the N+1 cycles after a tick.
    int  m_cur [N];
    int  m_tgt [N];
    bit  m_on  [N];
    bit  m_trip;
    bit  m_ready;
    bit  m_live = 1'b0;
    int  m_wdt;
    int  m_cyc;
    int  m_last;

    function automatic int ramp(bit on, int cur, int tgt, int ctr, int stp);
        int goal, dlt;
        if (!on) return ctr;
        goal = ((cur - ctr) * (tgt - ctr) < 0) ? ctr : tgt;
        dlt  = goal - cur;
        if (dlt >= -stp && dlt <= stp) return goal;
        return (dlt > 0) ? cur + stp : cur - stp;
    endfunction

    function automatic int d(int k);
        return int'(duty_out[k*W +: W]);
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    initial forever begin : model
        int ph, tg, ctr;
        bit tick;
        @(posedge clk);
        ctr = int'(period) / 2;
        if (!reset_n) begin
            for (int k = 0; k < N; k++) begin
                m_cur[k] = ctr;
                m_tgt[k] = ctr;
                m_on[k]  = 1'b0;
            end
            m_trip = 1'b0;
            m_wdt  = 0;
            m_cyc  = 0;
            m_last = -100;
            m_live = 1'b1;
        end else if (m_live) begin
            ph = m_cyc - m_last;
            if (ph >= 1 && ph <= N) begin
                tg = (m_tgt[ph-1] > int'(period)) ? int'(period) : m_tgt[ph-1];
                m_cur[ph-1] = ramp(m_on[ph-1], m_cur[ph-1], tg, ctr, int'(step));
            end
            tick = (m_cyc % TD) == TD - 1;
            if (cmd_valid && !(ph >= 1 && ph <= N + 1)) begin
                m_on[cmd_motor]  = cmd_on;
                m_tgt[cmd_motor] = (int'(cmd_duty) > int'(period)) ? int'(period) : int'(cmd_duty);
                m_wdt  = 0;
                m_trip = 1'b0;
            end else if (tick && !m_trip) begin
                m_wdt++;
                if (m_wdt == WDT) begin
                    m_trip = 1'b1;
                    m_wdt  = 0;
                    for (int k = 0; k < N; k++) begin
                        m_on[k]  = 1'b0;
                        m_tgt[k] = ctr;
                        m_cur[k] = ctr;
                    end
                end
            end
            if (tick) m_last = m_cyc;
            m_cyc++;
        end
        ph = m_cyc - m_last;
        m_ready = !(ph >= 1 && ph <= N + 1);
    end

    initial forever begin : compare
        @(negedge clk);
        if (m_live) begin
            chk("cmd_ready", int'(cmd_ready), int'(m_ready));
            chk("wdt_tripped", int'(wdt_tripped), int'(m_trip));
            for (int k = 0; k < N; k++) begin
                chk($sformatf("on_out[%0d]", k), int'(on_out[k]), int'(m_on[k]));
                chk($sformatf("duty_out[%0d]", k), d(k), m_cur[k]);
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int m, input bit on, input int dv);
        int n;
        bit r;
        sync();
        cmd_valid = 1'b1;
        cmd_motor = 2'(m);
        cmd_on    = on;
        cmd_duty  = 16'(dv);
        n = 0;
        do begin
            @(negedge clk);
            r = cmd_ready;
            sync();
            n++;
        end while (!r && n < 64);
        cmd_valid = 1'b0;
        if (!r) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_bound: command to ch%0d not accepted within 64 cycles", m);
        end
    endtask

    // Returns at the negedge of the first IDLE cycle after a complete sweep.
    task automatic tick_wait();
        int n;
        n = 0;
        while (cmd_ready !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        while (cmd_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tick_wait_bound: no sweep completed within 64 cycles");
        end
    endtask

    initial begin
        int n, lows;
        bit quiet;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_duty0", d(0), 500);
        chk("rst_duty3", d(3), 500);
        chk("rst_on", int'(on_out), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_trip", int'(wdt_tripped), 0);

        send(0, 1'b1, 800);
        tick_wait(); chk("ramp38_t1", d(0), 600);
        send(3, 1'b0, 500);
        tick_wait(); chk("ramp38_t2", d(0), 700);
        send(3, 1'b0, 500);
        tick_wait(); chk("ramp38_t3", d(0), 800);
        send(3, 1'b0, 500);
        tick_wait(); chk("ramp38_t4", d(0), 800);

        sync(); step = 16'd300;
        send(1, 1'b1, 700);
        tick_wait(); chk("rev39_pre", d(1), 700);
        send(1, 1'b1, 200);
        tick_wait(); chk("rev39_center", d(1), 500);
        send(3, 1'b0, 500);
        tick_wait(); chk("rev39_far", d(1), 200);

        sync(); step = 16'd400;
        send(2, 1'b1, 900);
        tick_wait(); chk("off42_pre", d(2), 900);
        sync(); step = 16'd0;
        send(2, 1'b0, 900);
        tick_wait(); chk("off42_snap", d(2), 500); chk("off42_on", int'(on_out[2]), 0);
        sync(); step = 16'd600;
        send(2, 1'b1, 1200);
        tick_wait(); chk("clamp42", d(2), 1000);

        sync();
        n = 0;
        while (cmd_ready !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b1; cmd_motor = 2'd3; cmd_on = 1'b1; cmd_duty = 16'd500;
        lows = 1;
        while (n < 64) begin
            @(negedge clk);
            n++;
            if (cmd_ready) break;
            lows++;
        end
        chk("busy40_cycles", lows, N + 1);
        sync();
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("busy40_accept", int'(on_out[3]), 1);

        sync();
        tick_wait();
        tick_wait(); chk("wdt41_pre", int'(wdt_tripped), 0);
        tick_wait(); chk("wdt41_trip", int'(wdt_tripped), 1);
        chk("wdt41_on", int'(on_out), 0);
        for (int k = 0; k < N; k++) chk($sformatf("wdt41_duty%0d", k), d(k), 500);
        send(0, 1'b1, 500);
        @(negedge clk);
        chk("wdt41_clear", int'(wdt_tripped), 0);

        for (int b = 0; b < 40; b++) begin
            quiet = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < 64; c++) begin
                sync();
                cmd_valid = !quiet && ($urandom_range(0, 2) == 0);
                cmd_motor = 2'($urandom_range(0, 3));
                cmd_on    = ($urandom_range(0, 3) != 0);
                cmd_duty  = 16'($urandom_range(0, 1600));
                if ($urandom_range(0, 99) == 0)
                    case ($urandom_range(0, 3))
                        0: period = 16'd1000;
                        1: period = 16'd600;
                        2: period = 16'd1500;
                        default: period = 16'd2000;
                    endcase
                if ($urandom_range(0, 49) == 0) step = 16'($urandom_range(0, 500));
                reset_n = ($urandom_range(0, 299) != 0);
            end
        end
        sync();
        cmd_valid = 1'b0;
        reset_n   = 1'b1;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/motor_ramp_scheduler.md
MOTOR_RAMP_SCHEDULER -- requirements
Module: motor_ramp_scheduler

Interface
REQ-001 Parameter NUM_MOTORS, default 4: number of H-bridge channels scheduled.
REQ-002 Parameter PERIOD_LENGTH, default 16: width of period and duty values.
REQ-003 Parameter TICK_DIV, default 16000: clk cycles per ramp tick (1 ms at 16 MHz); SHALL be >= NUM_MOTORS+2.
REQ-004 Parameter WDT_TICKS, default 500: ticks without an accepted command before the watchdog trips.
REQ-005 The block SHALL use one clock; reset is synchronous and active-low.
REQ-006 clk  in  1  single rising-edge clock.
REQ-007 reset_n  in  1  synchronous active-low reset.
REQ-008 period  in  PERIOD_LENGTH  PWM period shared by all channels; center = period>>1.
REQ-009 step  in  PERIOD_LENGTH  maximum duty change per tick per channel.
REQ-010 cmd_valid  in  1  command present.
REQ-011 cmd_ready  out  1  command can be accepted this cycle.
REQ-012 cmd_motor  in  clog2(NUM_MOTORS)  target channel index.
REQ-013 cmd_on  in  1  channel enable.
REQ-014 cmd_duty  in  PERIOD_LENGTH  target duty (center = brake, above = forward, below = reverse).
REQ-015 on_out  out  NUM_MOTORS  per-channel enable to the motor controllers.
REQ-016 duty_out  out  NUM_MOTORS*PERIOD_LENGTH  per-channel current duty, channel i at bits [i*W +: W].
REQ-017 wdt_tripped  out  1  watchdog has forced all channels off.

Function
REQ-018 A prescaler SHALL count 0..TICK_DIV-1 and wrap; it SHALL emit a one-cycle tick when the count equals TICK_DIV-1.
REQ-019 The FSM SHALL have states IDLE, UPDATE and DONE; IDLE->UPDATE on tick, UPDATE holds for NUM_MOTORS cycles servicing channel k in the k-th cycle, then DONE for one cycle, then IDLE.
REQ-020 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid && cmd_ready.
REQ-021 An accepted command SHALL store on[cmd_motor] = cmd_on and target[cmd_motor] = min(cmd_duty, period) at the end of the cycle.
REQ-022 A command accepted in the same cycle as a tick SHALL be used by that tick's update.
REQ-023 For channel k, duty_out SHALL change at the end of UPDATE cycle k, i.e. it is visible k+2 cycles after the tick.
REQ-024 Ramp rule when on[k]=1 and current and target are on the same side of center, or current == center: current moves toward target by min(step, |target-current|).
REQ-025 When current and target are on opposite sides of center, current SHALL move toward center by at most step and clamp at exactly center; it SHALL NOT cross center within one tick.
REQ-026 If on[k]=0, the update SHALL set current[k] = center regardless of target; on_out[k] SHALL mirror on[k].
REQ-027 step = 0 SHALL produce no movement, except for the off-snap in REQ-026.
REQ-028 A period change SHALL take effect at the next update: targets above period clamp to period, and center is recomputed from the live period.
REQ-029 The watchdog SHALL count ticks, clear on every accepted command, and trip when it reaches WDT_TICKS.
REQ-030 On trip: wdt_tripped=1, all on=0, all targets and currents = center, in the trip cycle.
REQ-031 A command accepted in the trip cycle SHALL take precedence: no trip occurs and the counter clears.
REQ-032 wdt_tripped SHALL clear on the next accepted command.
REQ-033 Arithmetic SHALL be unsigned at PERIOD_LENGTH bits; no intermediate value may wrap below 0 or above period.

Reset
REQ-034 On reset_n=0 at a clock edge: state=IDLE, prescaler=0, watchdog=0, wdt_tripped=0, on_out=0, and every target and duty_out = period>>1 using the period sampled in that cycle.
REQ-035 Reset asserted mid-UPDATE SHALL abandon the sweep; the next cycle is IDLE with cmd_ready=1.

Structure
REQ-036 A shared package SHALL hold PERIOD_LENGTH, the default NUM_MOTORS and the FSM state encoding.
REQ-037 Per-channel ramp arithmetic (REQ-024..027) SHALL be one combinational sub-module, motor_ramp_step, instanced once and time-shared across the UPDATE cycles.

Verification
REQ-038 period=1000, step=100, ch0 on, cmd_duty=800 -> duty_out[0] = 600, 700, 800, 800 on successive ticks.
REQ-039 ch1 at 700, cmd_duty=200, step=300 -> duty_out[1] = 500 (clamped at center), then 200.
REQ-040 cmd_valid held high during UPDATE -> cmd_ready=0 for NUM_MOTORS+1 cycles after the tick and the command is accepted in the first IDLE cycle.
REQ-041 WDT_TICKS=3, no commands -> wdt_tripped=1 after the 3rd tick, on_out=0 and all duty_out=500; the next command clears wdt_tripped.
REQ-042 Command with cmd_on=0 to ch2 at 900 -> duty_out[2]=500 on the next update regardless of step; cmd_duty=1200 with period=1000 -> target 1000.
